// File: rtl/reg_scan_display_pkg.sv
// Shared types and constants for the register scan display.
package reg_scan_display_pkg;

  // Read-port sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Segment patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/reg_scan_display_hex_to_7seg.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module hex_to_7seg
  import reg_scan_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Table lookup of the glyph for one nibble.
  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_HEX_0;
      4'h1: seg_o = SEG_HEX_1;
      4'h2: seg_o = SEG_HEX_2;
      4'h3: seg_o = SEG_HEX_3;
      4'h4: seg_o = SEG_HEX_4;
      4'h5: seg_o = SEG_HEX_5;
      4'h6: seg_o = SEG_HEX_6;
      4'h7: seg_o = SEG_HEX_7;
      4'h8: seg_o = SEG_HEX_8;
      4'h9: seg_o = SEG_HEX_9;
      4'hA: seg_o = SEG_HEX_A;
      4'hB: seg_o = SEG_HEX_B;
      4'hC: seg_o = SEG_HEX_C;
      4'hD: seg_o = SEG_HEX_D;
      4'hE: seg_o = SEG_HEX_E;
      4'hF: seg_o = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/reg_scan_display.sv
// Reads the register bank over a req/ack port and shows address and
// contents on a 4-digit multiplexed active-low 7-segment display.
//
// Read handshake: rd_req is raised one cycle after entering REQ and held
// high, with rd_addr stable, until a one-cycle rd_ack (rd_data valid in
// that same cycle) or until the timeout expires. rd_ack seen outside REQ
// is ignored; an ack in the expiry cycle still counts as a good read.
module reg_scan_display
  import reg_scan_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int DWELL_FRAMES = 100,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [1:0] sel_addr,
  output logic       rd_req,
  output logic [1:0] rd_addr,
  input  logic       rd_ack,
  input  logic [7:0] rd_data,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FRM_W = $clog2(DWELL_FRAMES + 1);
  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(DWELL_FRAMES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [1:0]       digit_q;
  logic             live_q;
  logic             frame_end;

  state_e           state_q, state_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]       addr_q, addr_d;
  logic             req_q, req_d;
  logic [7:0]       shadow_q, shadow_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [3:0]       nib;
  logic [6:0]       dec_seg;

  // Digit refresh: divider and digit select; live_q enables the anodes
  // from the first cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      digit_q   <= 2'd0;
      live_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_q <= '0;
        digit_q   <= digit_q + 2'd1;
      end else begin
        div_cnt_q <= div_cnt_q + DIV_W'(1);
      end
    end
  end

  assign frame_end = (div_cnt_q == DIV_LAST) && (digit_q == 2'd3);

  // Read sequencer next-state: issue reads, capture data or timeout, and
  // pick the next address at frame boundaries while holding.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_d       = req_q;
    shadow_d    = shadow_q;
    valid_d     = valid_q;
    err_d       = err_q;
    tmo_cnt_d   = tmo_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_end && (frame_cnt_q != '1)) begin
      frame_cnt_d = frame_cnt_q + FRM_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        addr_d    = 2'd0;
        tmo_cnt_d = '0;
        state_d   = ST_REQ;
      end
      ST_REQ: begin
        req_d     = 1'b1;
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (rd_ack) begin
          shadow_d  = rd_data;
          valid_d   = 1'b1;
          err_d     = 1'b0;
          req_d     = 1'b0;
          tmo_cnt_d = '0;
          state_d   = ST_HOLD;
        end else if (tmo_cnt_q == TMO_LAST) begin
          valid_d   = 1'b1;
          err_d     = 1'b1;
          req_d     = 1'b0;
          tmo_cnt_d = '0;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        req_d     = 1'b0;
        tmo_cnt_d = '0;
        if (frame_end) begin
          if (!scan_en) begin
            addr_d      = sel_addr;
            frame_cnt_d = '0;
            state_d     = ST_REQ;
          end else if (frame_cnt_q >= FRM_LAST) begin
            addr_d      = addr_q + 2'd1;
            frame_cnt_d = '0;
            state_d     = ST_REQ;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read sequencer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= 2'd0;
      req_q       <= 1'b0;
      shadow_q    <= 8'h00;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      tmo_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      shadow_q    <= shadow_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      tmo_cnt_q   <= tmo_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rd_req  = req_q;
  assign rd_addr = addr_q;

  // Nibble shown on the active digit, fed to the single decoder.
  always_comb begin
    nib = shadow_q[3:0];
    case (digit_q)
      2'd3:    nib = {2'b00, addr_q};
      2'd1:    nib = shadow_q[7:4];
      default: nib = shadow_q[3:0];
    endcase
  end

  hex_to_7seg u_hex (
    .hex_i (nib),
    .seg_o (dec_seg)
  );

  // Digit drive with blank/dash overrides and the error decimal point.
  always_comb begin
    an  = ~(4'b0001 << digit_q);
    seg = dec_seg;
    dp  = 1'b1;
    case (digit_q)
      2'd3: dp = ~err_q;
      2'd2: seg = SEG_BLANK;
      default: begin
        if (!valid_q) begin
          seg = SEG_BLANK;
        end else if (err_q) begin
          seg = SEG_DASH;
        end
      end
    endcase
    if (!live_q) begin
      an  = 4'b1111;
      seg = SEG_BLANK;
      dp  = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scan_display.sv
// Bench for reg_scan_display: bank model with programmable ack delay,
// rd_req rise monitor, and a display model derived from glyph tables.
module tb_reg_scan_display;

  localparam int RDIV  = 4;
  localparam int DWELL = 2;
  localparam int TMO   = 8;
  localparam int FRAME = 4 * RDIV;
  localparam int STEP  = FRAME * DWELL;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_en = 1'b0;
  logic [1:0] sel_addr = 2'd0;
  logic       rd_req;
  logic [1:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  reg_scan_display #(
    .REFRESH_DIV  (RDIV),
    .DWELL_FRAMES (DWELL),
    .ACK_TIMEOUT  (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scan_en  (scan_en),
    .sel_addr (sel_addr),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- bank model ----------------
  // Acks on the ack_at-th cycle rd_req is seen high (0 = never ack).
  logic [7:0] bank [4];
  int         ack_at = 3;
  int         req_cnt = 0;
  logic       ack_drv = 1'b0;
  logic [7:0] data_drv = 8'h00;
  logic       stray_ack = 1'b0;
  logic [7:0] stray_data = 8'h00;

  assign rd_ack  = ack_drv | stray_ack;
  assign rd_data = stray_ack ? stray_data : data_drv;

  always @(negedge clk) begin
    if (rd_req === 1'b1) req_cnt = req_cnt + 1;
    else req_cnt = 0;
    ack_drv  = (ack_at != 0) && (req_cnt == ack_at);
    data_drv = bank[rd_addr];
  end

  // ---------------- rd_req rise monitor ----------------
  int         cyc = 0;
  logic       prev_req = 1'b0;
  int         rise_t[$];
  logic [1:0] rise_a[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rd_req === 1'b1 && prev_req !== 1'b1) begin
      rise_t.push_back(cyc);
      rise_a.push_back(rd_addr);
    end
    prev_req = rd_req;
  end

  // ---------------- display model ----------------
  function automatic logic [6:0] lit_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic int digit_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int d, input logic [1:0] a,
                                         input logic [7:0] x, input bit v, input bit e);
    if (d == 3) return ~lit_of({2'b00, a});
    if (d == 2 || !v) return 7'h7F;
    if (e) return 7'b0111111;
    return ~lit_of(d == 1 ? x[7:4] : x[3:0]);
  endfunction

  function automatic logic exp_dp(input int d, input bit e);
    return (d == 3 && e) ? 1'b0 : 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_rise(input logic [1:0] want, input bit any, input int max, output bit ok);
    logic prev;
    ok = 1'b0;
    prev = rd_req;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (rd_req === 1'b1 && prev !== 1'b1 && (any || rd_addr == want)) ok = 1'b1;
      prev = rd_req;
    end
  endtask

  task automatic wait_read(input logic [1:0] want, input int max, output bit ok);
    wait_rise(want, 1'b0, max, ok);
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        if (rd_req === 1'b0) ok = 1'b1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit ok;
    int d;
    scan_en = 1'b0; sel_addr = 2'd0; ack_at = 3;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (an !== 4'b1111) begin failures++; $display("FAIL reset_an: got %b want 1111", an); end
    checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b want 1", dp); end
    checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
    rst = 1'b1;
    wait_rise(2'd0, 1'b1, 3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL reset_first_req: got no rise want rise within 2 cycles"); end
    checks++; if (rd_addr !== 2'd0) begin failures++; $display("FAIL reset_first_addr: got %0d want 0", rd_addr); end
    d = digit_of(an);
    checks++;
    if (d < 0 || seg !== exp_seg(d, 2'd0, 8'h00, 1'b0, 1'b0)) begin
      failures++; $display("FAIL reset_blank_digits: an=%b seg=%b want seg=%b", an, seg, exp_seg(d, 2'd0, 8'h00, 1'b0, 1'b0));
    end
  endtask

  task automatic test_manual();
    bit ok;
    int d;
    logic [1:0] s;
    scan_en = 1'b0; ack_at = 3;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin s = 2'd2; bank[2] = 8'hA3; end
      else begin s = 2'($urandom_range(0, 3)); bank[s] = 8'($urandom_range(0, 255)); end
      sel_addr = s;
      wait_read(s, 80, ok);
      checks++; if (!ok) begin failures++; $display("FAIL manual_read: got no read of addr %0d want one", s); end
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        d = digit_of(an);
        checks++;
        if (d < 0 || seg !== exp_seg(d, s, bank[s], 1'b1, 1'b0) || dp !== exp_dp(d, 1'b0)) begin
          failures++;
          $display("FAIL manual_display: an=%b seg=%b dp=%b want seg=%b dp=%b", an, seg, dp,
                   exp_seg(d, s, bank[s], 1'b1, 1'b0), exp_dp(d, 1'b0));
        end
      end
    end
  endtask

  task automatic test_stray_ack();
    bit ok;
    int d;
    scan_en = 1'b0; ack_at = 3; sel_addr = 2'd0;
    bank[0] = 8'($urandom_range(0, 255));
    wait_read(2'd0, 80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stray_setup_read: got no read want one"); end
    stray_data = ~bank[0];
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      d = digit_of(an);
      checks++;
      if (d < 0 || seg !== exp_seg(d, 2'd0, bank[0], 1'b1, 1'b0) || dp !== exp_dp(d, 1'b0)) begin
        failures++;
        $display("FAIL stray_ack_ignored: an=%b seg=%b dp=%b want seg=%b dp=%b", an, seg, dp,
                 exp_seg(d, 2'd0, bank[0], 1'b1, 1'b0), exp_dp(d, 1'b0));
      end
    end
  endtask

  task automatic test_scan();
    bit ok;
    int d;
    logic [1:0] a;
    logic [1:0] exp_q[$];
    bank[0] = 8'h15; bank[1] = 8'h01; bank[2] = 8'hA3; bank[3] = 8'h87;
    scan_en = 1'b1; ack_at = 3;
    do_reset();
    rise_t.delete(); rise_a.delete();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 5; k++) begin
      a = 2'(k % 4);
      wait_read(a, 80, ok);
      checks++; if (!ok) begin failures++; $display("FAIL scan_read: got no read of addr %0d want one", a); end
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        d = digit_of(an);
        checks++;
        if (d < 0 || seg !== exp_seg(d, a, bank[a], 1'b1, 1'b0) || dp !== exp_dp(d, 1'b0)) begin
          failures++;
          $display("FAIL scan_display: addr=%0d an=%b seg=%b dp=%b want seg=%b", a, an, seg, dp,
                   exp_seg(d, a, bank[a], 1'b1, 1'b0));
        end
      end
    end
    checks++;
    if (rise_a.size() < 5) begin
      failures++; $display("FAIL scan_rise_count: got %0d want >=5", rise_a.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        a = exp_q.pop_front();
        checks++;
        if (rise_a[i] !== a) begin failures++; $display("FAIL scan_addr_seq[%0d]: got %0d want %0d", i, rise_a[i], a); end
      end
      for (int i = 2; i < 5; i++) begin
        checks++;
        if (rise_t[i] - rise_t[i-1] != STEP) begin
          failures++; $display("FAIL scan_interval[%0d]: got %0d want %0d", i, rise_t[i] - rise_t[i-1], STEP);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int d;
    int n;
    scan_en = 1'b0; sel_addr = 2'd1; ack_at = 0;
    wait_rise(2'd1, 1'b0, 80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_req: got no request want one"); end
    n = 1;
    for (int i = 0; i < 20 && rd_req === 1'b1; i++) begin
      @(negedge clk);
      if (rd_req === 1'b1) n++;
    end
    checks++; if (n != TMO - 1) begin failures++; $display("FAIL timeout_req_len: got %0d want %0d", n, TMO - 1); end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      d = digit_of(an);
      checks++;
      if (d < 0 || seg !== exp_seg(d, 2'd1, 8'h00, 1'b1, 1'b1) || dp !== exp_dp(d, 1'b1)) begin
        failures++;
        $display("FAIL timeout_display: an=%b seg=%b dp=%b want seg=%b dp=%b", an, seg, dp,
                 exp_seg(d, 2'd1, 8'h00, 1'b1, 1'b1), exp_dp(d, 1'b1));
      end
    end
  endtask

  task automatic test_ack_timeout_collision();
    bit ok;
    int d;
    int n;
    scan_en = 1'b0; sel_addr = 2'd3; ack_at = TMO - 1;
    bank[3] = 8'($urandom_range(0, 255));
    wait_rise(2'd3, 1'b0, 80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL collision_req: got no request want one"); end
    n = 1;
    for (int i = 0; i < 20 && rd_req === 1'b1; i++) begin
      @(negedge clk);
      if (rd_req === 1'b1) n++;
    end
    checks++; if (n != TMO - 1) begin failures++; $display("FAIL collision_req_len: got %0d want %0d", n, TMO - 1); end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      d = digit_of(an);
      checks++;
      if (d < 0 || seg !== exp_seg(d, 2'd3, bank[3], 1'b1, 1'b0) || dp !== exp_dp(d, 1'b0)) begin
        failures++;
        $display("FAIL collision_display: an=%b seg=%b dp=%b want seg=%b dp=%b", an, seg, dp,
                 exp_seg(d, 2'd3, bank[3], 1'b1, 1'b0), exp_dp(d, 1'b0));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int d;
    scan_en = 1'b1; sel_addr = 2'd2; ack_at = 0;
    wait_rise(2'd0, 1'b1, 80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midreset_req: got no request want one"); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (rd_req !== 1'b0) begin failures++; $display("FAIL midreset_rd_req: got %b want 0", rd_req); end
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      failures++; $display("FAIL midreset_display: an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
    end
    @(negedge clk);
    rst = 1'b1;
    ack_at = 3;
    wait_rise(2'd0, 1'b1, 4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midreset_restart: got no request want one"); end
    checks++; if (rd_addr !== 2'd0) begin failures++; $display("FAIL midreset_addr: got %0d want 0", rd_addr); end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rd_req === 1'b0) ok = 1'b1;
    end
    checks++; if (!ok) begin failures++; $display("FAIL midreset_ack: got no completion want one"); end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      d = digit_of(an);
      checks++;
      if (d < 0 || seg !== exp_seg(d, 2'd0, bank[0], 1'b1, 1'b0) || dp !== exp_dp(d, 1'b0)) begin
        failures++;
        $display("FAIL midreset_display_after: an=%b seg=%b dp=%b want seg=%b", an, seg, dp,
                 exp_seg(d, 2'd0, bank[0], 1'b1, 1'b0));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bank[0] = 8'h15; bank[1] = 8'h01; bank[2] = 8'hA3; bank[3] = 8'h87;
    test_reset();
    test_manual();
    test_stray_ack();
    test_scan();
    test_timeout();
    test_ack_timeout_collision();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no completion by 200000 want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
